// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: synchronised/debounced button, red-phase-aligned WALK then FLASH,
// aborts to a safe don't-walk as soon as the vehicle signal leaves red. All outputs registered.
module ped_crossing_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned WALK_CYCLES     = 6,
    parameter int unsigned FLASH_CYCLES    = 4,
    parameter int unsigned FLASH_PERIOD    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] lights,
    input  logic       ped_btn,
    output logic       walk,
    output logic       dont_walk,
    output logic       req_pending,
    output logic [3:0] countdown
);

    typedef enum logic [1:0] {IDLE, WAIT_RED, WALK, FLASH} state_t;

    localparam logic [3:0] CD_TOTAL     = 4'(WALK_CYCLES + FLASH_CYCLES);
    localparam logic [3:0] CD_LAST_WALK = 4'(FLASH_CYCLES + 1);
    localparam logic [3:0] DB_LAST      = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] DB_MAX       = 4'(DEBOUNCE_CYCLES);
    localparam logic [7:0] DIV_LAST     = 8'(FLASH_PERIOD - 1);

    state_t     r_state, w_state_nxt;
    logic       r_sync1, r_sync2;
    logic [3:0] r_db_cnt;
    logic       r_prev_red;
    logic [7:0] r_div, w_div_nxt;
    logic       r_walk, r_dont_walk, r_req_pending;
    logic [3:0] r_countdown, w_cd_nxt;
    logic       w_walk_nxt, w_dw_nxt, w_pend_nxt;
    logic       w_press, w_red, w_red_rise;

    assign w_red      = (lights == 3'b100);
    assign w_red_rise = w_red & ~r_prev_red;
    // Counter saturates at DB_MAX, so the event fires only once per high run.
    assign w_press    = r_sync2 && (r_db_cnt == DB_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_cnt   <= 4'd0;
            r_prev_red <= 1'b1;
        end else begin
            r_sync1    <= ped_btn;
            r_sync2    <= r_sync1;
            r_prev_red <= w_red;
            if (!r_sync2)
                r_db_cnt <= 4'd0;
            else if (r_db_cnt != DB_MAX)
                r_db_cnt <= r_db_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_walk        <= 1'b0;
            r_dont_walk   <= 1'b1;
            r_req_pending <= 1'b0;
            r_countdown   <= 4'd0;
            r_div         <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_walk        <= w_walk_nxt;
            r_dont_walk   <= w_dw_nxt;
            r_req_pending <= w_pend_nxt;
            r_countdown   <= w_cd_nxt;
            r_div         <= w_div_nxt;
        end
    end

    // Countdown doubles as the phase timer; in FLASH, req_pending holds the latched request.
    always_comb begin
        w_state_nxt = r_state;
        w_walk_nxt  = 1'b0;
        w_dw_nxt    = 1'b1;
        w_pend_nxt  = 1'b0;
        w_cd_nxt    = 4'd0;
        w_div_nxt   = 8'd0;
        case (r_state)
            IDLE: begin
                if (w_press) begin
                    w_state_nxt = WAIT_RED;
                    w_pend_nxt  = 1'b1;
                end
            end
            WAIT_RED: begin
                w_pend_nxt = 1'b1;
                if (w_red_rise) begin
                    w_state_nxt = WALK;
                    w_walk_nxt  = 1'b1;
                    w_dw_nxt    = 1'b0;
                    w_pend_nxt  = 1'b0;
                    w_cd_nxt    = CD_TOTAL;
                end
            end
            WALK: begin
                if (!w_red) begin
                    w_state_nxt = IDLE;
                end else if (r_countdown == CD_LAST_WALK) begin
                    w_state_nxt = FLASH;
                    w_cd_nxt    = r_countdown - 4'd1;
                end else begin
                    w_walk_nxt = 1'b1;
                    w_dw_nxt   = 1'b0;
                    w_cd_nxt   = r_countdown - 4'd1;
                end
            end
            FLASH: begin
                w_pend_nxt = r_req_pending | w_press;
                if (!w_red || r_countdown == 4'd1) begin
                    w_state_nxt = w_pend_nxt ? WAIT_RED : IDLE;
                end else begin
                    w_cd_nxt = r_countdown - 4'd1;
                    if (r_div == DIV_LAST) begin
                        w_dw_nxt = ~r_dont_walk;
                    end else begin
                        w_dw_nxt  = r_dont_walk;
                        w_div_nxt = r_div + 8'd1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign walk        = r_walk;
    assign dont_walk   = r_dont_walk;
    assign req_pending = r_req_pending;
    assign countdown   = r_countdown;

endmodule

// File: doc/ped_crossing_ctrl.md
PED_CROSSING_CTRL -- requirements
Module: ped_crossing_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized-high cycles that qualify a button press (1..15).
REQ-002 SHALL have parameter WALK_CYCLES, default 6: cycles of solid walk (1..14).
REQ-003 SHALL have parameter FLASH_CYCLES, default 4: cycles of flashing dont_walk after walk (1..14); WALK_CYCLES+FLASH_CYCLES <= 15.
REQ-004 SHALL have parameter FLASH_PERIOD, default 2: cycles per dont_walk toggle during flash (>=1).
REQ-005 clk  input  1  sole clock, all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-007 lights  input  3  vehicle signal {R,Y,G} from the upstream traffic FSM; 3'b100 = red.
REQ-008 ped_btn  input  1  raw pedestrian push button, asynchronous to clk.
REQ-009 walk  output  1  walk lamp.
REQ-010 dont_walk  output  1  don't-walk lamp.
REQ-011 req_pending  output  1  "request accepted" lamp.
REQ-012 countdown  output  4  remaining crossing cycles; 0 outside crossing.

Function
REQ-013 ped_btn SHALL pass a 2-flop synchronizer, then a debounce counter; one press event SHALL fire on the cycle the synchronized level has been high DEBOUNCE_CYCLES consecutive cycles, at most once per high run; any low cycle clears the counter.
REQ-014 red SHALL mean lights==3'b100 exactly; any other code, including illegal codes (000, multi-hot), SHALL count as not red.
REQ-015 red_rise SHALL be red now AND prev_red==0, where prev_red is red registered one cycle.
REQ-016 States SHALL be IDLE, WAIT_RED, WALK, FLASH; all outputs registered.
REQ-017 IDLE: walk=0, dont_walk=1, req_pending=0; press event -> WAIT_RED.
REQ-018 WAIT_RED: req_pending=1, dont_walk=1; red_rise -> WALK on next cycle; presses ignored (already pending).
REQ-019 Entry into WAIT_RED SHALL NOT grant mid-red: a request made while red is already active waits for the next red_rise.
REQ-020 WALK: walk=1, dont_walk=0, req_pending=0; lasts exactly WALK_CYCLES cycles, then FLASH.
REQ-021 FLASH: walk=0; dont_walk=1 on first FLASH cycle, inverting every FLASH_PERIOD cycles; lasts exactly FLASH_CYCLES cycles.
REQ-022 countdown SHALL equal WALK_CYCLES+FLASH_CYCLES on the first WALK cycle, decrement by 1 every cycle, read 1 on the last FLASH cycle, and be 0 in IDLE/WAIT_RED.
REQ-023 Press events during WALK SHALL be dropped; press events during FLASH SHALL be latched (req_pending=1 from the next cycle).
REQ-024 FLASH end -> WAIT_RED if a request is latched, else IDLE; exit outputs: walk=0, dont_walk=1 solid.
REQ-025 Abort: if not red is sampled in WALK or FLASH, the next cycle SHALL have walk=0, dont_walk=1, countdown=0, next state per REQ-024.
REQ-026 Abort SHALL take priority over normal WALK->FLASH or FLASH-end transitions in the same cycle.
REQ-027 walk and dont_walk SHALL never both be 1; walk=1 only while red.

Reset
REQ-028 While reset==0 at a clk edge: state=IDLE, walk=0, dont_walk=1, req_pending=0, countdown=0, synchronizer/debounce cleared, prev_red=1.
REQ-029 prev_red=1 at reset SHALL prevent a grant into a red phase already in progress at reset release.
REQ-030 Reset asserted mid-WALK/FLASH SHALL take effect on that edge, dropping any latched request.

Verification
REQ-031 Button high 6 cycles while green, red then rises -> req_pending=1 4 cycles after sync; walk=1 from cycle after red_rise for 6 cycles; countdown 10..5 then flashing dont_walk 1,1,0,0 with countdown 4..1; then IDLE.
REQ-032 Button glitch high 3 cycles -> no press event, req_pending stays 0.
REQ-033 Press during red (mid-phase) -> no walk that red; walk starts after next red_rise.
REQ-034 lights goes 100->010 on 3rd WALK cycle -> next cycle walk=0, dont_walk=1, countdown=0, state IDLE.
REQ-035 Press during FLASH -> req_pending=1; after FLASH, WAIT_RED; served on next red_rise.
REQ-036 Release reset while lights=100 with button held -> no walk until following red_rise; reset=0 during WALK -> outputs at reset values next cycle.
